mem_bank_ctrl: RTL and testbench

MEM_BANK_CTRL -- requirements
Module: mem_bank_ctrl

---
 rtl/mem_bank_ctrl_if.sv | 43 ++++
 rtl/mem_bank_ctrl.sv | 81 ++++++++
 tb/tb_mem_bank_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bank_ctrl_if.sv
// Request/response handshake bundle between a requester and mem_bank_ctrl.
// Signal names mirror the controller's request/response ports.
interface mem_bank_ctrl_if #(
    parameter int AddrWidth = 9,
    parameter int DataSize  = 2
);
    localparam int DataBytes = 2 ** DataSize;
    localparam int DataWidth = 8 * DataBytes;

    logic                 req_valid_i;
    logic                 req_ready_o;
    logic                 req_we_i;
    logic [AddrWidth-1:0] req_addr_i;
    logic [DataWidth-1:0] req_wdata_i;
    logic [DataBytes-1:0] req_wstrb_i;
    logic                 rsp_valid_o;
    logic                 rsp_ready_i;
    logic [DataWidth-1:0] rsp_rdata_o;

    modport master (
        output req_valid_i,
        output req_we_i,
        output req_addr_i,
        output req_wdata_i,
        output req_wstrb_i,
        output rsp_ready_i,
        input  req_ready_o,
        input  rsp_valid_o,
        input  rsp_rdata_o
    );

    modport slave (
        input  req_valid_i,
        input  req_we_i,
        input  req_addr_i,
        input  req_wdata_i,
        input  req_wstrb_i,
        input  rsp_ready_i,
        output req_ready_o,
        output rsp_valid_o,
        output rsp_rdata_o
    );
endinterface

// File: rtl/mem_bank_ctrl.sv
// Front end for a single-cycle synchronous memory bank: passes requests
// straight to the bank and returns read data through a 3-deep in-order FIFO.
module mem_bank_ctrl #(
    parameter int  AddrWidth = 9,
    parameter int  DataSize  = 2,
    localparam int DataBytes = 2 ** DataSize,
    localparam int DataWidth = 8 * DataBytes
) (
    input  logic                 clk_i,
    input  logic                 arst_ni,
    mem_bank_ctrl_if.slave       bus,
    output logic                 mem_cs_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    output logic [DataBytes-1:0] mem_wstrb_o,
    input  logic [DataWidth-1:0] mem_rdata_i
);

    logic [1:0]           pend_q;
    logic                 cap_q;
    logic [1:0]           wr_ptr_q;
    logic [1:0]           rd_ptr_q;
    logic [1:0]           cnt_q;
    logic [DataWidth-1:0] fifo_q [3];

    logic fire;
    logic rd_fire;
    logic pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Ready depends only on the pending count, so every accepted read
    // is guaranteed a FIFO slot when its data returns.
    assign bus.req_ready_o = (pend_q != 2'd3);

    assign fire    = bus.req_valid_i & bus.req_ready_o & arst_ni;
    assign rd_fire = fire & ~bus.req_we_i;
    assign pop     = bus.rsp_valid_o & bus.rsp_ready_i;

    assign mem_cs_o    = fire;
    assign mem_addr_o  = bus.req_addr_i;
    assign mem_wdata_o = bus.req_wdata_i;
    assign mem_wstrb_o = bus.req_we_i ? bus.req_wstrb_i : '0;

    assign bus.rsp_valid_o = (cnt_q != 2'd0);
    assign bus.rsp_rdata_o = bus.rsp_valid_o ? fifo_q[rd_ptr_q] : '0;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            pend_q   <= '0;
            cap_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            pend_q <= pend_q + {1'b0, rd_fire} - {1'b0, pop};
            cap_q  <= rd_fire;
            cnt_q  <= cnt_q + {1'b0, cap_q} - {1'b0, pop};
            if (cap_q) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

    // Bank data is valid the cycle after chip select; capture it then.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            for (int i = 0; i < 3; i++) begin
                fifo_q[i] <= '0;
            end
        end else if (cap_q) begin
            fifo_q[wr_ptr_q] <= mem_rdata_i;
        end
    end

endmodule

// File: tb/tb_mem_bank_ctrl.sv
// Directed and randomized checks of mem_bank_ctrl against a byte-level
// memory model and an in-order expected-response queue.
module tb_mem_bank_ctrl;
    localparam int AW = 9;
    localparam int DS = 2;
    localparam int DB = 4;
    localparam int DW = 32;

    logic clk_i = 1'b0;
    logic arst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    mem_bank_ctrl_if #(.AddrWidth(AW), .DataSize(DS)) bus();

    logic          mem_cs_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DB-1:0] mem_wstrb_o;
    logic [DW-1:0] mem_rdata_i = '0;

    mem_bank_ctrl #(.AddrWidth(AW), .DataSize(DS)) dut (
        .clk_i      (clk_i),
        .arst_ni    (arst_ni),
        .bus        (bus.slave),
        .mem_cs_o   (mem_cs_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_wstrb_o(mem_wstrb_o),
        .mem_rdata_i(mem_rdata_i)
    );

    logic [7:0] bank    [128][DB];
    logic [7:0] ref_mem [128][DB];

    initial begin
        for (int w = 0; w < 128; w++) begin
            for (int b = 0; b < DB; b++) begin
                bank[w][b]    = 8'h00;
                ref_mem[w][b] = 8'h00;
            end
        end
    end

    // Memory bank: synchronous, read data valid the cycle after cs.
    always @(posedge clk_i) begin
        if (mem_cs_o) begin
            for (int b = 0; b < DB; b++) begin
                mem_rdata_i[8*b+:8] <= bank[mem_addr_o[AW-1:DS]][b];
                if (mem_wstrb_o[b]) begin
                    bank[mem_addr_o[AW-1:DS]][b] <= mem_wdata_o[8*b+:8];
                end
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int n_pop = 0;
    logic seen = 1'b0;
    time first_pop_t = 0;
    time last_pop_t = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Scoreboard: transactions sampled mid-cycle, when inputs are stable.
    always @(negedge clk_i) begin
        int w;
        logic [31:0] e;
        if (!arst_ni) begin
            exp_q.delete();
        end else begin
            if (bus.rsp_valid_o && bus.rsp_ready_i) begin
                chk("rsp_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    chk("rsp_data", bus.rsp_rdata_o, exp_q.pop_front());
                end
                if (!seen) begin
                    first_pop_t = $time;
                    seen = 1'b1;
                end
                last_pop_t = $time;
                n_pop++;
            end
            if (bus.req_valid_i && bus.req_ready_o) begin
                w = int'(bus.req_addr_i[AW-1:DS]);
                if (bus.req_we_i) begin
                    for (int b = 0; b < DB; b++) begin
                        if (bus.req_wstrb_i[b]) begin
                            ref_mem[w][b] = bus.req_wdata_i[8*b+:8];
                        end
                    end
                end else begin
                    for (int b = 0; b < DB; b++) begin
                        e[8*b+:8] = ref_mem[w][b];
                    end
                    exp_q.push_back(e);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DB-1:0] s);
        bus.req_valid_i = v;
        bus.req_we_i    = we;
        bus.req_addr_i  = a;
        bus.req_wdata_i = d;
        bus.req_wstrb_i = s;
    endtask

    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_i);
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
            nxt();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int lows;
        int vhigh;
        time t0;

        // Reset: cs forced low even with a valid request present
        drive(1'b1, 1'b0, '0, '0, 4'hF);
        bus.rsp_ready_i = 1'b0;
        #3;
        chk("rst_cs", 32'(mem_cs_o), 32'd0);
        chk("rst_rvalid", 32'(bus.rsp_valid_o), 32'd0);
        chk("rst_rdata", bus.rsp_rdata_o, 32'd0);
        nxt();
        nxt();
        arst_ni = 1'b1;
        drive(1'b0, 1'b0, '0, '0, '0);
        mid();
        chk("rst_ready", 32'(bus.req_ready_o), 32'd1);
        chk("rst_rvalid2", 32'(bus.rsp_valid_o), 32'd0);
        nxt();

        // Write then read back with 2-cycle latency
        bus.rsp_ready_i = 1'b1;
        drive(1'b1, 1'b1, 9'd0, 32'h12345678, 4'hF);
        mid();
        chk("wr_cs", 32'(mem_cs_o), 32'd1);
        chk("wr_strb", 32'(mem_wstrb_o), 32'hF);
        chk("wr_data", mem_wdata_o, 32'h12345678);
        nxt();
        drive(1'b1, 1'b0, 9'd0, 32'hFFFFFFFF, 4'hF);
        mid();
        chk("rd_strb", 32'(mem_wstrb_o), 32'd0);
        nxt();
        drive(1'b0, 1'b0, '0, '0, '0);
        mid();
        chk("lat_n1", 32'(bus.rsp_valid_o), 32'd0);
        nxt();
        mid();
        chk("lat_n2", 32'(bus.rsp_valid_o), 32'd1);
        chk("rd_first", bus.rsp_rdata_o, 32'h12345678);
        nxt();
        mid();
        chk("lat_n3", 32'(bus.rsp_valid_o), 32'd0);
        nxt();

        // Zero-strobe write leaves the word untouched
        drive(1'b1, 1'b1, 9'd0, 32'h87654321, 4'hF);
        nxt();
        drive(1'b1, 1'b1, 9'd0, 32'h98765432, 4'h0);
        mid();
        chk("w0_strb", 32'(mem_wstrb_o), 32'd0);
        nxt();
        drive(1'b1, 1'b0, 9'd0, 32'h0, 4'hF);
        mid();
        chk("rd2_strb", 32'(mem_wstrb_o), 32'd0);
        chk("rd2_cs", 32'(mem_cs_o), 32'd1);
        nxt();
        drive(1'b0, 1'b0, '0, '0, '0);
        nxt();
        mid();
        chk("rd2_valid", 32'(bus.rsp_valid_o), 32'd1);
        chk("rd2_data", bus.rsp_rdata_o, 32'h87654321);
        nxt();

        // Backpressure: 3 reads outstanding, 4th stalls
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b1, 9'(4 * i), 32'hA0A0A0A0 + 32'(i) * 32'h01010101, 4'hF);
            nxt();
        end
        drive(1'b0, 1'b0, '0, '0, '0);
        bus.rsp_ready_i = 1'b0;
        nxt();
        base = n_pop;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b0, 9'(4 * i), '0, 4'hF);
            mid();
            chk("bp_ready", 32'(bus.req_ready_o), 32'd1);
            nxt();
        end
        drive(1'b1, 1'b0, 9'd16, '0, 4'hF);
        mid();
        chk("bp_stall", 32'(bus.req_ready_o), 32'd0);
        chk("bp_cs", 32'(mem_cs_o), 32'd0);
        nxt();
        mid();
        chk("bp_stall2", 32'(bus.req_ready_o), 32'd0);
        chk("bp_hvalid", 32'(bus.rsp_valid_o), 32'd1);
        chk("bp_head", bus.rsp_rdata_o, 32'hA1A1A1A1);
        nxt();
        bus.rsp_ready_i = 1'b1;
        mid();
        chk("bp_pop_rdy", 32'(bus.req_ready_o), 32'd0);
        nxt();
        mid();
        chk("bp_resume", 32'(bus.req_ready_o), 32'd1);
        chk("bp_cs4", 32'(mem_cs_o), 32'd1);
        nxt();
        drive(1'b0, 1'b0, '0, '0, '0);
        drain();
        chk("bp_count", 32'(n_pop - base), 32'd4);

        // Throughput: one read per cycle with rsp_ready held
        base = n_pop;
        lows = 0;
        seen = 1'b0;
        t0 = 0;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 1'b0, 9'(4 * i), '0, 4'hF);
            mid();
            if (i == 0) t0 = $time;
            if (!bus.req_ready_o) lows++;
            nxt();
        end
        drive(1'b0, 1'b0, '0, '0, '0);
        drain();
        chk("tp_lows", 32'(lows), 32'd0);
        chk("tp_count", 32'(n_pop - base), 32'd100);
        chk("tp_latency", 32'(first_pop_t - t0), 32'd20);
        chk("tp_span", 32'(last_pop_t - first_pop_t), 32'd990);

        // Reset with two reads buffered
        bus.rsp_ready_i = 1'b0;
        drive(1'b1, 1'b0, 9'd4, '0, 4'hF);
        nxt();
        drive(1'b1, 1'b0, 9'd8, '0, 4'hF);
        nxt();
        drive(1'b0, 1'b0, '0, '0, '0);
        nxt();
        nxt();
        mid();
        chk("rr_buffered", 32'(bus.rsp_valid_o), 32'd1);
        nxt();
        arst_ni = 1'b0;
        drive(1'b1, 1'b0, 9'd4, '0, 4'hF);
        #1;
        chk("rr_valid_now", 32'(bus.rsp_valid_o), 32'd0);
        chk("rr_cs", 32'(mem_cs_o), 32'd0);
        chk("rr_rdata", bus.rsp_rdata_o, 32'd0);
        nxt();
        arst_ni = 1'b1;
        drive(1'b0, 1'b0, '0, '0, '0);
        bus.rsp_ready_i = 1'b1;
        base = n_pop;
        vhigh = 0;
        for (int i = 0; i < 4; i++) begin
            mid();
            if (bus.rsp_valid_o) vhigh++;
            nxt();
        end
        chk("rr_no_valid", 32'(vhigh), 32'd0);
        chk("rr_no_rsp", 32'(n_pop - base), 32'd0);
        drive(1'b1, 1'b0, 9'd4, '0, 4'hF);
        nxt();
        drive(1'b0, 1'b0, '0, '0, '0);
        nxt();
        mid();
        chk("rr_after_v", 32'(bus.rsp_valid_o), 32'd1);
        chk("rr_after_d", bus.rsp_rdata_o, 32'hA1A1A1A1);
        nxt();

        // Random traffic checked by the scoreboard
        for (int i = 0; i < 10000; i++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  9'($urandom_range(0, 63)), $urandom, 4'($urandom));
            bus.rsp_ready_i = $urandom_range(0, 3) != 0;
            nxt();
        end
        drive(1'b0, 1'b0, '0, '0, '0);
        bus.rsp_ready_i = 1'b1;
        drain();
        chk("rnd_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
